// File: rtl/riscv_pkg.sv
// Shared definitions for the pipeline datapath: default widths, ALU op codes and
// forwarding-select encodings.
package riscv_pkg;

  localparam int unsigned DefaultDataWidth    = 32;
  localparam int unsigned DefaultControlWidth = 3;

  typedef enum logic [2:0] {
    AluAdd   = 3'b000,
    AluSub   = 3'b001,
    AluAnd   = 3'b010,
    AluOr    = 3'b011,
    AluSll   = 3'b100,
    AluSlt   = 3'b101,
    AluRsvd  = 3'b110,
    AluPassB = 3'b111
  } alu_op_e;

  // 2'b11 is not listed; consumers fall back to the register operand.
  typedef enum logic [1:0] {
    FwdReg = 2'b00,
    FwdWb  = 2'b01,
    FwdMem = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub/and/or/sll/slt/pass-B, with a zero flag for branches.
module alu
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DefaultDataWidth,
  parameter int unsigned CONTROL_WIDTH = DefaultControlWidth
) (
  input  logic [DATA_WIDTH-1:0]    src_a,
  input  logic [DATA_WIDTH-1:0]    src_b,
  input  logic [CONTROL_WIDTH-1:0] control,
  output logic [DATA_WIDTH-1:0]    result,
  output logic                     zero
);

  logic slt;

  assign slt = $signed(src_a) < $signed(src_b);

  always_comb begin
    result = '0;
    case (control)
      AluAdd:   result = src_a + src_b;
      AluSub:   result = src_a - src_b;
      AluAnd:   result = src_a & src_b;
      AluOr:    result = src_a | src_b;
      AluSll:   result = src_a << src_b[4:0];
      AluSlt:   result = {{(DATA_WIDTH-1){1'b0}}, slt};
      AluPassB: result = src_b;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, branch/jump redirect and
// the EX/MEM register.
module execute_stage
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DefaultDataWidth,
  parameter int unsigned CONTROL_WIDTH = DefaultControlWidth
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_e,
  input  logic                     flush_e,
  input  logic [DATA_WIDTH-1:0]    rd1_d,
  input  logic [DATA_WIDTH-1:0]    rd2_d,
  input  logic [DATA_WIDTH-1:0]    pc_d,
  input  logic [DATA_WIDTH-1:0]    imm_ext_d,
  input  logic [4:0]               rd_d,
  input  logic                     reg_write_d,
  input  logic                     mem_write_d,
  input  logic                     alu_src_d,
  input  logic                     branch_d,
  input  logic                     jump_d,
  input  logic [1:0]               result_src_d,
  input  logic [CONTROL_WIDTH-1:0] alu_control_d,
  input  logic [1:0]               forward_a_e,
  input  logic [1:0]               forward_b_e,
  input  logic [DATA_WIDTH-1:0]    result_w,
  output logic                     pc_src_e,
  output logic [DATA_WIDTH-1:0]    pc_target_e,
  output logic [DATA_WIDTH-1:0]    alu_result_m,
  output logic [DATA_WIDTH-1:0]    write_data_m,
  output logic [4:0]               rd_m,
  output logic                     reg_write_m,
  output logic                     mem_write_m,
  output logic [1:0]               result_src_m
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    rd1;
    logic [DATA_WIDTH-1:0]    rd2;
    logic [DATA_WIDTH-1:0]    pc;
    logic [DATA_WIDTH-1:0]    imm_ext;
    logic [4:0]               rd;
    logic                     reg_write;
    logic                     mem_write;
    logic                     alu_src;
    logic                     branch;
    logic                     jump;
    logic [1:0]               result_src;
    logic [CONTROL_WIDTH-1:0] alu_control;
  } id_ex_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] write_data;
    logic [4:0]            rd;
    logic                  reg_write;
    logic                  mem_write;
    logic [1:0]            result_src;
  } ex_mem_t;

  id_ex_t  id_ex_d, id_ex_q;
  ex_mem_t ex_mem_d, ex_mem_q;

  logic [DATA_WIDTH-1:0] src_a, fwd_b, src_b, alu_result;
  logic                  alu_zero;

  // A bubble is an all-zero entry, so flush simply wins over stall.
  always_comb begin
    id_ex_d = id_ex_q;
    if (flush_e) begin
      id_ex_d = '0;
    end else if (!stall_e) begin
      id_ex_d.rd1         = rd1_d;
      id_ex_d.rd2         = rd2_d;
      id_ex_d.pc          = pc_d;
      id_ex_d.imm_ext     = imm_ext_d;
      id_ex_d.rd          = rd_d;
      id_ex_d.reg_write   = reg_write_d;
      id_ex_d.mem_write   = mem_write_d;
      id_ex_d.alu_src     = alu_src_d;
      id_ex_d.branch      = branch_d;
      id_ex_d.jump        = jump_d;
      id_ex_d.result_src  = result_src_d;
      id_ex_d.alu_control = alu_control_d;
    end
  end

  always_comb begin
    src_a = id_ex_q.rd1;
    case (forward_a_e)
      FwdWb:   src_a = result_w;
      FwdMem:  src_a = ex_mem_q.alu_result;
      default: src_a = id_ex_q.rd1;
    endcase
  end

  always_comb begin
    fwd_b = id_ex_q.rd2;
    case (forward_b_e)
      FwdWb:   fwd_b = result_w;
      FwdMem:  fwd_b = ex_mem_q.alu_result;
      default: fwd_b = id_ex_q.rd2;
    endcase
  end

  assign src_b = id_ex_q.alu_src ? id_ex_q.imm_ext : fwd_b;

  alu #(
    .DATA_WIDTH   (DATA_WIDTH),
    .CONTROL_WIDTH(CONTROL_WIDTH)
  ) u_alu (
    .src_a  (src_a),
    .src_b  (src_b),
    .control(id_ex_q.alu_control),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign pc_src_e    = id_ex_q.jump | (id_ex_q.branch & alu_zero);
  assign pc_target_e = id_ex_q.pc + id_ex_q.imm_ext;

  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.alu_result = alu_result;
    ex_mem_d.write_data = fwd_b;
    ex_mem_d.rd         = id_ex_q.rd;
    ex_mem_d.reg_write  = id_ex_q.reg_write;
    ex_mem_d.mem_write  = id_ex_q.mem_write;
    ex_mem_d.result_src = id_ex_q.result_src;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
    end
  end

  assign alu_result_m = ex_mem_q.alu_result;
  assign write_data_m = ex_mem_q.write_data;
  assign rd_m         = ex_mem_q.rd;
  assign reg_write_m  = ex_mem_q.reg_write;
  assign mem_write_m  = ex_mem_q.mem_write;
  assign result_src_m = ex_mem_q.result_src;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus queues expectations tagged with the cycle
// they should appear in; a negedge monitor pops and compares them.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, stall_e, flush_e;
  logic [31:0] rd1_d, rd2_d, pc_d, imm_ext_d, result_w;
  logic [4:0]  rd_d;
  logic        reg_write_d, mem_write_d, alu_src_d, branch_d, jump_d;
  logic [1:0]  result_src_d, forward_a_e, forward_b_e;
  logic [2:0]  alu_control_d;
  logic        pc_src_e, reg_write_m, mem_write_m;
  logic [31:0] pc_target_e, alu_result_m, write_data_m;
  logic [4:0]  rd_m;
  logic [1:0]  result_src_m;

  execute_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall_e      (stall_e),
    .flush_e      (flush_e),
    .rd1_d        (rd1_d),
    .rd2_d        (rd2_d),
    .pc_d         (pc_d),
    .imm_ext_d    (imm_ext_d),
    .rd_d         (rd_d),
    .reg_write_d  (reg_write_d),
    .mem_write_d  (mem_write_d),
    .alu_src_d    (alu_src_d),
    .branch_d     (branch_d),
    .jump_d       (jump_d),
    .result_src_d (result_src_d),
    .alu_control_d(alu_control_d),
    .forward_a_e  (forward_a_e),
    .forward_b_e  (forward_b_e),
    .result_w     (result_w),
    .pc_src_e     (pc_src_e),
    .pc_target_e  (pc_target_e),
    .alu_result_m (alu_result_m),
    .write_data_m (write_data_m),
    .rd_m         (rd_m),
    .reg_write_m  (reg_write_m),
    .mem_write_m  (mem_write_m),
    .result_src_m (result_src_m)
  );

  always #5 clk = ~clk;

  // kind: 0 alu_result_m, 1 {pc_src_e,pc_target_e}, 2 {reg_write_m,mem_write_m},
  //       3 any-nonzero of all registered outputs and pc_src_e, 4 write_data_m, 5 {rd_m,result_src_m}
  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] observe(input int kind);
    case (kind)
      0: return {32'b0, alu_result_m};
      1: return {31'b0, pc_src_e, pc_target_e};
      2: return {62'b0, reg_write_m, mem_write_m};
      3: return {63'b0, |{pc_src_e, alu_result_m, write_data_m, rd_m, reg_write_m,
                          mem_write_m, result_src_m}};
      4: return {32'b0, write_data_m};
      5: return {57'b0, rd_m, result_src_m};
      default: return 64'hX;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      logic [63:0] act;
      cur = sb.pop_front();
      act = observe(cur.kind);
      total++;
      if (cur.cyc != cyc || act !== cur.exp) begin
        bad++;
        $display("FAIL %s cyc=%0d due=%0d actual=%0h required=%0h",
                 cur.name, cyc, cur.cyc, act, cur.exp);
      end
    end
  end

  task automatic push(input int at, input int kind, input logic [63:0] v, input string n);
    exp_t e;
    int   pos;
    e.cyc = at; e.kind = kind; e.exp = v; e.name = n;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > at) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] r1, input logic [31:0] r2, input logic [2:0] ctl,
                       input logic asrc = 1'b0, input logic [31:0] imm = 32'h0,
                       input logic [31:0] pc = 32'h0, input logic br = 1'b0,
                       input logic jp = 1'b0, input logic rw = 1'b1, input logic mw = 1'b0,
                       input logic [4:0] rd = 5'd1, input logic [1:0] rs = 2'd0);
    rd1_d = r1; rd2_d = r2; alu_control_d = ctl; alu_src_d = asrc; imm_ext_d = imm;
    pc_d = pc; branch_d = br; jump_d = jp; reg_write_d = rw; mem_write_d = mw;
    rd_d = rd; result_src_d = rs;
  endtask

  task automatic nop();
    drive(32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
  endtask

  logic [31:0] va [11] = '{32'h8000_0000, 32'h8000_0000, 32'h1, 32'hF0F0_00FF, 32'hF0F0_00FF,
                           32'h1, 32'h0, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3};
  logic [31:0] vb [11] = '{32'h1, 32'h1, 32'h8000_0000, 32'h0FF0_0F0F, 32'h0FF0_0F0F,
                           32'h24, 32'h1234_5000, 32'h3, 32'h2, 32'h0, 32'h5};
  logic [2:0]  vc [11] = '{3'b101, 3'b001, 3'b101, 3'b010, 3'b011,
                           3'b100, 3'b111, 3'b110, 3'b000, 3'b101, 3'b001};
  logic [31:0] ve [11] = '{32'h1, 32'h7FFF_FFFF, 32'h0, 32'h00F0_000F, 32'hFFF0_0FFF,
                           32'h10, 32'h1234_5000, 32'h0, 32'h1, 32'h1, 32'hFFFF_FFFE};

  initial begin
    int k;
    rst = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    forward_a_e = 2'b00; forward_b_e = 2'b00; result_w = 32'hDEAD_BEEF;
    // Non-zero decode inputs while in reset: nothing may leak through.
    drive(32'd5, 32'd7, 3'b000, 1'b0, 32'h10, 32'h100, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 2'd2);
    push(2, 3, 64'h0, "reset_clear");
    tick(); tick();
    total++;
    if (alu_result_m !== 32'h0) begin
      bad++;
      $display("FAIL reset_alu_result actual=%0h", alu_result_m);
    end
    total++;
    if (pc_src_e !== 1'b0) begin
      bad++;
      $display("FAIL reset_pc_src actual=%0b", pc_src_e);
    end
    rst = 1'b0;
    nop();

    k = cyc;
    drive(32'd5, 32'd7, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 2'd1);
    push(k + 2, 0, 64'd12, "add_5_7");
    push(k + 2, 2, 64'b10, "add_ctl");
    push(k + 2, 5, {57'b0, 5'd7, 2'd1}, "add_rd_rsrc");
    push(k + 2, 4, 64'd7, "add_wdata");
    push(k + 1, 3, 64'h0, "add_not_in_mem_yet");
    tick();

    for (int i = 0; i < 11; i++) begin
      k = cyc;
      drive(va[i], vb[i], vc[i]);
      push(k + 2, 0, {32'b0, ve[i]}, $sformatf("alu_vec%0d", i));
      tick();
    end
    nop(); tick(); tick();

    // Forwarding: MEM path on A, WB path on A, MEM path on B.
    k = cyc;
    drive(32'd10, 32'd20, 3'b000);
    push(k + 2, 0, 64'd30, "fwd_producer");
    tick();
    drive(32'd999, 32'd1, 3'b000);
    push(k + 3, 0, 64'd31, "fwd_a_mem");
    tick();
    forward_a_e = 2'b10;
    drive(32'd1, 32'd5, 3'b000);
    push(k + 4, 0, 64'h1005, "fwd_a_wb");
    tick();
    forward_a_e = 2'b01; result_w = 32'h1000;
    drive(32'd2, 32'd777, 3'b000);
    push(k + 5, 0, 64'h1007, "fwd_b_mem");
    push(k + 5, 4, 64'h1005, "fwd_b_wdata");
    tick();
    forward_a_e = 2'b00; forward_b_e = 2'b10;
    nop();
    tick();
    forward_b_e = 2'b00;

    // Immediate operand, with forward select 11 acting as the register operand.
    k = cyc;
    drive(32'd3, 32'd55, 3'b000, 1'b1, 32'h40);
    push(k + 2, 0, 64'h43, "imm_add_fwd11");
    push(k + 2, 4, 64'd55, "imm_store_data");
    tick();
    forward_a_e = 2'b11;
    nop();
    tick();
    forward_a_e = 2'b00;

    // Branch taken / not taken, then jump with a negative offset.
    k = cyc;
    drive(32'd9, 32'd9, 3'b001, 1'b0, 32'h20, 32'h100, 1'b1, 1'b0, 1'b0);
    push(k + 1, 1, 64'h1_0000_0120, "beq_taken");
    tick();
    drive(32'd9, 32'd8, 3'b001, 1'b0, 32'h20, 32'h100, 1'b1, 1'b0, 1'b0);
    push(k + 2, 1, 64'h0_0000_0120, "beq_not_taken");
    tick();
    drive(32'd0, 32'd0, 3'b000, 1'b0, 32'hFFFF_FFF0, 32'h200, 1'b0, 1'b1, 1'b1);
    push(k + 3, 1, 64'h1_0000_01F0, "jal_taken");
    tick();
    nop(); tick();

    // Stall and flush together: flush wins.
    k = cyc;
    drive(32'd1, 32'd1, 3'b000, 1'b0, 32'h8, 32'h300, 1'b0, 1'b1, 1'b1);
    push(k + 1, 1, 64'h1_0000_0308, "sf_jump_in_ex");
    tick();
    stall_e = 1'b1; flush_e = 1'b1;
    push(k + 2, 1, 64'h0, "sf_bubble_pcsrc");
    push(k + 2, 2, 64'b10, "sf_prev_rw");
    tick();
    stall_e = 1'b0; flush_e = 1'b0;
    nop();
    push(k + 3, 2, 64'b00, "sf_bubble_rw");
    tick(); tick();

    // Stall alone holds ID/EX for three edges.
    k = cyc;
    drive(32'd100, 32'd23, 3'b000);
    tick();
    stall_e = 1'b1;
    drive(32'd1, 32'd1, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int j = 2; j <= 5; j++) push(k + j, 0, 64'd123, $sformatf("stall_hold%0d", j));
    push(k + 6, 0, 64'd2, "stall_release");
    push(k + 6, 2, 64'b00, "stall_release_rw");
    tick(); tick(); tick();
    stall_e = 1'b0;
    tick();
    nop();
    tick(); tick();

    // Reset during a stall with a jump sitting in ID/EX.
    k = cyc;
    drive(32'd4, 32'd4, 3'b000, 1'b0, 32'h10, 32'h400, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 2'd2);
    push(k + 1, 1, 64'h1_0000_0410, "rst_jump_in_ex");
    tick();
    stall_e = 1'b1; rst = 1'b1;
    push(k + 2, 3, 64'h0, "rst_over_stall");
    tick();
    rst = 1'b0; stall_e = 1'b0;
    nop();
    tick(); tick(); tick();
    total++;
    if (reg_write_m !== 1'b0) begin
      bad++;
      $display("FAIL final_nop_rw actual=%0b", reg_write_m);
    end

    while (sb.size() > 0) begin
      cur = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s never checked: due=%0d now=%0d", cur.name, cur.cyc, cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
